// File: rtl/ps2_scancode_receiver.sv
// PS/2 device-to-host receiver: synchronizes and debounces the keyboard
// lines, deframes 11-bit frames, checks odd parity and the stop bit, and
// shifts each accepted byte into a two-byte history register.
module ps2_scancode_receiver #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [15:0] key_press,
    output logic        scan_valid,
    output logic        parity_err,
    output logic        frame_err
);

    localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0]    FILT_MAX = 8'(FILTER_LEN - 1);
    localparam logic [TW-1:0] TO_MAX   = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    // Lane 0 is ps2_clk, lane 1 is ps2_data.
    logic [1:0] raw_in;
    logic [1:0] sync1_reg;
    logic [1:0] sync2_reg;

    assign raw_in = {ps2_data, ps2_clk};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            // Two-flop synchronizer per PS/2 line; idles high like the bus.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    sync1_reg[gi] <= 1'b1;
                    sync2_reg[gi] <= 1'b1;
                end else begin
                    sync1_reg[gi] <= raw_in[gi];
                    sync2_reg[gi] <= sync1_reg[gi];
                end
            end
        end
    endgenerate

    logic clk_sync;
    logic data_sync;
    assign clk_sync  = sync2_reg[0];
    assign data_sync = sync2_reg[1];

    // Glitch filter: fclk follows the synced clock only after FILTER_LEN
    // consecutive samples that disagree with the current filtered level.
    logic       fclk_reg;
    logic       fclk_next;
    logic [7:0] filt_cnt_reg;
    logic [7:0] filt_cnt_next;
    logic       fall;

    // Filter next-state: count disagreeing samples, flip level on the last one.
    always_comb begin
        fclk_next     = fclk_reg;
        filt_cnt_next = 8'd0;
        if (clk_sync != fclk_reg) begin
            if (filt_cnt_reg == FILT_MAX) begin
                fclk_next     = clk_sync;
                filt_cnt_next = 8'd0;
            end else begin
                filt_cnt_next = filt_cnt_reg + 8'd1;
            end
        end
    end

    // Filter state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fclk_reg     <= 1'b1;
            filt_cnt_reg <= 8'd0;
        end else begin
            fclk_reg     <= fclk_next;
            filt_cnt_reg <= filt_cnt_next;
        end
    end

    // Strobe in the cycle the filtered clock drops; data is sampled alongside.
    assign fall = fclk_reg & ~fclk_next;

    state_t        state_reg,    state_next;
    logic [2:0]    bit_cnt_reg,  bit_cnt_next;
    logic [7:0]    shift_reg,    shift_next;
    logic          par_reg,      par_next;
    logic [TW-1:0] to_cnt_reg,   to_cnt_next;
    logic [15:0]   key_reg,      key_next;
    logic          valid_reg,    valid_next;
    logic          perr_reg,     perr_next;
    logic          ferr_reg,     ferr_next;

    // Frame FSM next-state, timeout supervision and output pulse generation.
    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        par_next     = par_reg;
        to_cnt_next  = to_cnt_reg;
        key_next     = key_reg;
        valid_next   = 1'b0;
        perr_next    = 1'b0;
        ferr_next    = 1'b0;

        if (state_reg == IDLE) begin
            to_cnt_next = '0;
            if (fall) begin
                if (!data_sync) begin
                    state_next   = DATA;
                    bit_cnt_next = 3'd0;
                end else begin
                    ferr_next = 1'b1;
                end
            end
        end else if (fall) begin
            to_cnt_next = '0;
            case (state_reg)
                DATA: begin
                    shift_next   = {data_sync, shift_reg[7:1]};
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    if (bit_cnt_reg == 3'd7) begin
                        state_next = PARITY;
                    end
                end
                PARITY: begin
                    par_next   = data_sync;
                    state_next = STOP;
                end
                default: begin
                    // Stop bit: a bad stop bit outranks a parity failure.
                    state_next = IDLE;
                    if (!data_sync) begin
                        ferr_next = 1'b1;
                    end else if (^{shift_reg, par_reg}) begin
                        key_next   = {key_reg[7:0], shift_reg};
                        valid_next = 1'b1;
                    end else begin
                        perr_next = 1'b1;
                    end
                end
            endcase
        end else if (to_cnt_reg == TO_MAX) begin
            // Keyboard stopped clocking mid-frame; abandon it.
            state_next  = IDLE;
            to_cnt_next = '0;
            ferr_next   = 1'b1;
        end else begin
            to_cnt_next = to_cnt_reg + TW'(1);
        end
    end

    // Frame FSM and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= 3'd0;
            shift_reg   <= 8'd0;
            par_reg     <= 1'b0;
            to_cnt_reg  <= '0;
            key_reg     <= 16'h0000;
            valid_reg   <= 1'b0;
            perr_reg    <= 1'b0;
            ferr_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            shift_reg   <= shift_next;
            par_reg     <= par_next;
            to_cnt_reg  <= to_cnt_next;
            key_reg     <= key_next;
            valid_reg   <= valid_next;
            perr_reg    <= perr_next;
            ferr_reg    <= ferr_next;
        end
    end

    assign key_press  = key_reg;
    assign scan_valid = valid_reg;
    assign parity_err = perr_reg;
    assign frame_err  = ferr_reg;

endmodule

// File: doc/ps2_scancode_receiver.md
Name: ps2_scancode_receiver

Overview:
Front end of the synthboard keyboard path. Samples the PS/2 keyboard clock and data lines, deframes 11-bit device-to-host frames, and checks parity and stop bits. Each accepted scancode byte is shifted into a 16-bit two-byte history register, key_press, which the tone-select logic decodes directly. A break is seen as {F0, code}; a make is seen as {prev, code}.

Parameters:
FILTER_LEN, 8, consecutive identical synchronized ps2_clk samples required before the filtered clock level changes (range 2..255).
TIMEOUT_CYCLES, 10000, clk cycles without a filtered ps2_clk falling edge before an in-progress frame is aborted (200 us at 50 MHz).

Ports:
clk  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous reset, active-low.
ps2_clk  input  1  raw PS/2 clock from the keyboard; asynchronous.
ps2_data  input  1  raw PS/2 data from the keyboard; asynchronous.
key_press  output  16  [15:8] previous accepted byte, [7:0] most recent accepted byte.
scan_valid  output  1  1-cycle pulse when key_press has just been updated.
parity_err  output  1  1-cycle pulse when a frame is dropped for bad odd parity.
frame_err  output  1  1-cycle pulse when a frame is dropped for bad start bit, bad stop bit, or timeout.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low. While rst_n=0 at a clk edge: key_press=16'h0000; scan_valid, parity_err, frame_err = 0; state=IDLE; shift, bit and timeout counters cleared; filtered clock = 1; synchronizers = 1.
- Reset mid-frame discards the partial frame with no error pulse.
- Input conditioning: ps2_clk and ps2_data each pass through a 2-flop synchronizer. Filtered clock (fclk) copies the synced ps2_clk only after FILTER_LEN consecutive equal samples. A falling edge (fall) is a 1-cycle strobe when fclk goes 1->0. Synced ps2_data is sampled in the same cycle as fall.
- FSM states: IDLE, DATA, PARITY, STOP. All transitions happen only on fall, except timeout.
  - IDLE: data=0 -> DATA, bit counter=0. data=1 -> stay in IDLE, pulse frame_err.
  - DATA: shift data in LSB first (shift <= {data, shift[7:1]}). After the 8th bit -> PARITY.
  - PARITY: latch the parity bit -> STOP.
  - STOP: always return to IDLE. The frame is good when data=1 and XOR(8 data bits, parity bit)=1 (odd parity).
    - Good frame: key_press <= {key_press[7:0], byte}; scan_valid=1 for one cycle.
    - Stop bit=0: frame_err pulse; key_press unchanged. This takes precedence over a parity error.
    - Stop bit ok, parity bad: parity_err pulse; key_press unchanged.
- Latency: key_press, scan_valid and error pulses are registered outputs, valid the cycle after the fall that sampled the stop bit.
- Timeout: in DATA, PARITY or STOP the counter increments each cycle and clears on fall. When it reaches TIMEOUT_CYCLES-1, go to IDLE and pulse frame_err; key_press is unchanged. In IDLE the counter is held at 0.
- Scancode handling: no filtering of E0, F0 or repeats. Every good byte is shifted in, including F0, E0 and typematic repeats; a repeat of byte X gives {X, X}. The outputs never pulse simultaneously; at most one pulse per frame.
- Host-to-device transmission is not supported; both PS/2 lines are input-only.

Test Plan:
- Reset, then send frame 0x16 (data 0,1,1,0,1,0,0,0 LSB first; parity 0; stop 1) at a 12 kHz PS/2 clock -> key_press=16'h0016, one scan_valid pulse, no error pulses.
- Send 0x16, then 0xF0 (parity 1), then 0x16 -> key_press = 0x0016, then 0x16F0, then 0xF016; exactly three scan_valid pulses.
- Send 0x1C with its parity bit inverted (1 instead of 0) -> one parity_err pulse, key_press keeps its prior value, no scan_valid. A following good 0x1C updates the low byte to 0x1C.
- Stop bit driven 0, then a separate frame with 4 clocks only followed by idle for more than TIMEOUT_CYCLES -> two frame_err pulses, key_press unchanged. A following good frame 0x45 is accepted.
- Glitch: 3-cycle low pulses on ps2_clk while idle (FILTER_LEN=8) -> no state change, no pulses. Assert rst_n=0 for one cycle after the 5th bit of a frame, then send a full 0x4A -> key_press=16'h004A, no error pulses.
